// File: rtl/sample_packer.sv
// sample_packer: drains NCH first-word-fall-through sample FIFOs through an
// enable mask with round-robin arbitration. Each popped sample becomes one
// byte frame: a header {HDR_TAG, channel}, then the zero-extended sample MSB
// byte first. The frame is written into an 8-bit write queue that can apply
// backpressure. A 16-bit counter tracks completed frames.
// Optional feature: define SAMPLE_PACKER_CHECKSUM_EN to append an XOR
// checksum byte (header ^ payload bytes) to every frame.
module sample_packer #(
    parameter int         NCH     = 5,
    parameter int         W       = 10,
    parameter logic [3:0] HDR_TAG = 4'hA
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH*W-1:0] in_smp,
    input  logic [NCH-1:0]   em_smp,
    output logic [NCH-1:0]   pp_smp,
    input  logic [NCH-1:0]   en,
    output logic [7:0]       out_write,
    output logic             ld_write,
    input  logic             fl_write,
    output logic             busy,
    output logic [15:0]      frames
);

    localparam int NB = (W + 7) / 8;
    localparam int PW = NB * 8;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

`ifdef SAMPLE_PACKER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2, CSUM = 2'd3} state_t;

    // XOR of the header byte and every payload byte of a frame.
    function automatic logic [7:0] frame_csum(input logic [7:0] hdr, input logic [PW-1:0] pay);
        logic [7:0] acc;
        acc = hdr;
        for (int b = 0; b < NB; b++) begin
            acc = acc ^ pay[b*8 +: 8];
        end
        return acc;
    endfunction
`else
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2} state_t;
`endif

    state_t          state_r, state_s;
    logic [CW-1:0]   rr_r, rr_s;
    logic [CW-1:0]   ch_r, ch_s;
    logic [W-1:0]    smp_r, smp_s;
    logic [IW-1:0]   idx_r, idx_s;
    logic [NCH-1:0]  pp_r, pp_s;
    logic [15:0]     frames_r, frames_s;

    logic            hit_s;
    logic [CW-1:0]   pick_s;
    logic [W-1:0]    sel_smp_s;
    logic [7:0]      hdr_s;
    logic [PW-1:0]   pay_s;
    logic [7:0]      byte_s;
    logic            load_s;

    // Round-robin scan starting just after the last served channel; rr itself is checked last.
    always_comb begin
        logic [CW-1:0] c_v;
        hit_s  = 1'b0;
        pick_s = '0;
        c_v    = '0;
        for (int k = 1; k <= NCH; k++) begin
            c_v = CW'((int'(rr_r) + k) % NCH);
            if (!hit_s && en[c_v] && !em_smp[c_v]) begin
                hit_s  = 1'b1;
                pick_s = c_v;
            end else begin
                hit_s  = hit_s;
            end
        end
    end

    // Mux the head sample of the selected channel.
    always_comb begin
        sel_smp_s = '0;
        for (int c = 0; c < NCH; c++) begin
            if (pick_s == CW'(c)) begin
                sel_smp_s = in_smp[c*W +: W];
            end else begin
                sel_smp_s = sel_smp_s;
            end
        end
    end

    assign hdr_s = {HDR_TAG, 4'(ch_r)};
    assign pay_s = PW'(smp_r);

    // Select payload byte idx of the held sample (idx NB-1 is the MSB byte).
    always_comb begin
        byte_s = 8'h00;
        for (int b = 0; b < NB; b++) begin
            if (idx_r == IW'(b)) begin
                byte_s = pay_s[b*8 +: 8];
            end else begin
                byte_s = byte_s;
            end
        end
    end

    // Next-state, pop pulse, frame counting and the write-queue strobe/byte.
    // A byte is never loaded while reset is asserted, so an abandoned frame emits nothing more.
    always_comb begin
        state_s   = state_r;
        rr_s      = rr_r;
        ch_s      = ch_r;
        smp_s     = smp_r;
        idx_s     = idx_r;
        pp_s      = '0;
        frames_s  = frames_r;
        load_s    = 1'b0;
        out_write = 8'h00;
        case (state_r)
            IDLE: begin
                if (hit_s) begin
                    ch_s         = pick_s;
                    rr_s         = pick_s;
                    smp_s        = sel_smp_s;
                    pp_s[pick_s] = 1'b1;
                    state_s      = HDR;
                end else begin
                    state_s      = IDLE;
                end
            end
            HDR: begin
                load_s = !fl_write && !rst;
                if (load_s) begin
                    out_write = hdr_s;
                    idx_s     = IW'(NB - 1);
                    state_s   = DATA;
                end else begin
                    out_write = 8'h00;
                end
            end
            DATA: begin
                load_s = !fl_write && !rst;
                if (load_s) begin
                    out_write = byte_s;
                    if (idx_r != '0) begin
                        idx_s = idx_r - IW'(1);
                    end else begin
`ifdef SAMPLE_PACKER_CHECKSUM_EN
                        state_s  = CSUM;
`else
                        state_s  = IDLE;
                        frames_s = frames_r + 16'd1;
`endif
                    end
                end else begin
                    out_write = 8'h00;
                end
            end
`ifdef SAMPLE_PACKER_CHECKSUM_EN
            CSUM: begin
                load_s = !fl_write && !rst;
                if (load_s) begin
                    out_write = frame_csum(hdr_s, pay_s);
                    frames_s  = frames_r + 16'd1;
                    state_s   = IDLE;
                end else begin
                    out_write = 8'h00;
                end
            end
`endif
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            rr_r     <= CW'(NCH - 1);
            ch_r     <= '0;
            smp_r    <= '0;
            idx_r    <= '0;
            pp_r     <= '0;
            frames_r <= 16'd0;
        end else begin
            state_r  <= state_s;
            rr_r     <= rr_s;
            ch_r     <= ch_s;
            smp_r    <= smp_s;
            idx_r    <= idx_s;
            pp_r     <= pp_s;
            frames_r <= frames_s;
        end
    end

    assign ld_write = load_s;
    assign pp_smp   = pp_r;
    assign frames   = frames_r;
    assign busy     = (state_r != IDLE);

endmodule
